// File: rtl/ann_coef_server.sv
`default_nettype none
// ============================================================================
//  Module   : ann_coef_server
//  Purpose  : Two-bank coefficient store for the ANN core. A byte stream from
//             the host loader fills bank 0 and then bank 1. Each request from
//             the ANN then streams the selected bank back, one coefficient per
//             cycle, with its index and a last-beat flag.
//  Revision : 1.0  initial release
// ============================================================================
module ann_coef_server #(
   parameter int COEF_WIDTH = 8,
   parameter int NUM_COEF   = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        load_en,
   input  logic [COEF_WIDTH-1:0]       load_data,
   input  logic                        reload,
   input  logic                        request_coef,
   input  logic                        coef_select,
   output logic                        image_weights_loaded,
   output logic                        busy,
   output logic                        coef_valid,
   output logic [COEF_WIDTH-1:0]       coef_data,
   output logic [$clog2(NUM_COEF)-1:0] coef_index,
   output logic                        coef_last
);

   localparam int c_AW    = $clog2(NUM_COEF);
   localparam int c_DEPTH = 2 * NUM_COEF;

   // With NUM_COEF a power of two, the final write address (2N-1) and the
   // final read index (N-1) are all-ones in their pointer widths.
   localparam logic [c_AW:0]   c_WP_LAST = '1;
   localparam logic [c_AW-1:0] c_RP_LAST = '1;

   localparam logic [1:0] c_LOAD   = 2'd0;
   localparam logic [1:0] c_READY  = 2'd1;
   localparam logic [1:0] c_STREAM = 2'd2;

   logic [1:0]            r_state;
   logic [1:0]            w_state_nxt;
   logic [COEF_WIDTH-1:0] r_mem [0:c_DEPTH-1];
   logic [c_AW:0]         r_wp;
   logic [c_AW-1:0]       r_rp;
   logic                  r_bank;
   logic                  r_coef_valid;
   logic [COEF_WIDTH-1:0] r_coef_data;
   logic [c_AW-1:0]       r_coef_index;
   logic                  r_coef_last;
   logic                  w_wr_en;
   logic                  w_start;
   logic                  w_beat;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_LOAD;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; reload wins over everything, and the state changes on
   // the final write / final beat so the pointers never need to wrap.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_LOAD: begin
            if (!reload && load_en && (r_wp == c_WP_LAST)) begin
               w_state_nxt = c_READY;
            end
         end
         c_READY: begin
            if (reload) begin
               w_state_nxt = c_LOAD;
            end else if (request_coef) begin
               w_state_nxt = c_STREAM;
            end
         end
         c_STREAM: begin
            if (reload) begin
               w_state_nxt = c_LOAD;
            end else if (r_rp == c_RP_LAST) begin
               w_state_nxt = c_READY;
            end
         end
         default: w_state_nxt = c_LOAD;
      endcase
   end

   // State-decoded controls and status; busy covers the trailing last beat.
   always_comb begin
      w_wr_en              = (r_state == c_LOAD)   && load_en && !reload;
      w_start              = (r_state == c_READY)  && request_coef && !reload;
      w_beat               = (r_state == c_STREAM) && !reload;
      image_weights_loaded = (r_state != c_LOAD);
      busy                 = (r_state == c_STREAM) || r_coef_valid;
   end

   // Storage, pointers and the registered stream outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < c_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wp         <= '0;
         r_rp         <= '0;
         r_bank       <= 1'b0;
         r_coef_valid <= 1'b0;
         r_coef_data  <= '0;
         r_coef_index <= '0;
         r_coef_last  <= 1'b0;
      end else begin
         if (reload) begin
            r_wp <= '0;
         end else if (w_wr_en) begin
            r_mem[r_wp] <= load_data;
            r_wp        <= r_wp + (c_AW+1)'(1);
         end

         if (w_start) begin
            r_bank <= coef_select;
            r_rp   <= '0;
         end else if (w_beat) begin
            r_rp <= r_rp + c_AW'(1);
         end

         // Data and index hold their last value once the stream ends.
         if (w_beat) begin
            r_coef_valid <= 1'b1;
            r_coef_data  <= r_mem[{r_bank, r_rp}];
            r_coef_index <= r_rp;
            r_coef_last  <= (r_rp == c_RP_LAST);
         end else begin
            r_coef_valid <= 1'b0;
            r_coef_last  <= 1'b0;
         end
      end
   end

   assign coef_valid = r_coef_valid;
   assign coef_data  = r_coef_data;
   assign coef_index = r_coef_index;
   assign coef_last  = r_coef_last;

endmodule
`default_nettype wire

// File: tb/tb_ann_coef_server.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ann_coef_server
//  Purpose  : Directed sequence with randomized load data, load gaps and
//             stray requests, checked against a coefficient-array model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ann_coef_server;

   localparam int N = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       load_en = 1'b0;
   logic [7:0] load_data = 8'h00;
   logic       reload = 1'b0;
   logic       request_coef = 1'b0;
   logic       coef_select = 1'b0;
   logic       image_weights_loaded;
   logic       busy;
   logic       coef_valid;
   logic [7:0] coef_data;
   logic [3:0] coef_index;
   logic       coef_last;

   logic [7:0] m_mem [0:2*N-1];
   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   ann_coef_server #(.COEF_WIDTH(8), .NUM_COEF(N)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .load_en              (load_en),
      .load_data            (load_data),
      .reload               (reload),
      .request_coef         (request_coef),
      .coef_select          (coef_select),
      .image_weights_loaded (image_weights_loaded),
      .busy                 (busy),
      .coef_valid           (coef_valid),
      .coef_data            (coef_data),
      .coef_index           (coef_index),
      .coef_last            (coef_last)
   );

   always #5 clk = ~clk;

   // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_valid"}, coef_valid, 0);
      chk({tag, "_busy"},  busy, 0);
      chk({tag, "_last"},  coef_last, 0);
   endtask

   // Load all 2N entries; val = base+i when rnd is 0, random otherwise.
   // Gaps carry stray requests, and the final write is paired with a request.
   task automatic load_all(input bit rnd, input logic [7:0] base);
      for (int i = 0; i < 2*N; i++) begin
         int gaps = $urandom_range(0, 2);
         if (i == 2*N-1) gaps = 1;
         for (int g = 0; g < gaps; g++) begin
            load_en      = 1'b0;
            load_data    = 8'($urandom);
            request_coef = $urandom_range(0, 1) == 1 || i == 2*N-1;
            coef_select  = 1'($urandom);
            step();
            request_coef = 1'b0;
            chk("load_gap_loaded", image_weights_loaded, 0);
            chk("load_gap_valid", coef_valid, 0);
         end
         load_en   = 1'b1;
         load_data = rnd ? 8'($urandom) : base + 8'(i);
         m_mem[i]  = load_data;
         request_coef = (i == 2*N-1);
         step();
         load_en      = 1'b0;
         request_coef = 1'b0;
         chk("load_loaded", image_weights_loaded, (i == 2*N-1) ? 1 : 0);
         chk("load_valid", coef_valid, 0);
      end
      chk("load_end_busy", busy, 0);
      step();
      chk_idle("load_end_req_ignored");
   endtask

   // Pulse a request (edge E0); the stream has not produced a beat yet.
   task automatic do_request(input bit bank);
      coef_select  = bank;
      request_coef = 1'b1;
      step();
      request_coef = 1'b0;
      coef_select  = 1'($urandom);
      chk("req_busy", busy, 1);
      chk("req_valid", coef_valid, 0);
   endtask

   // Check beats first..lastk; optionally pulse a stray request at beat 7.
   task automatic check_beats(input bit bank, input int first, input int lastk, input bit mid_req);
      for (int k = first; k <= lastk; k++) begin
         if (mid_req && k == 7) begin
            request_coef = 1'b1;
            coef_select  = ~bank;
         end
         step();
         request_coef = 1'b0;
         chk("beat_valid", coef_valid, 1);
         chk("beat_data",  coef_data,  m_mem[int'(bank)*N + k]);
         chk("beat_index", coef_index, k);
         chk("beat_last",  coef_last,  (k == N-1) ? 1 : 0);
         chk("beat_busy",  busy, 1);
      end
   endtask

   initial begin
      for (int i = 0; i < 2*N; i++) m_mem[i] = 8'h00;

      // Reset state.
      step();
      step();
      chk("rst_loaded", image_weights_loaded, 0);
      chk_idle("rst");
      chk("rst_data", coef_data, 0);
      chk("rst_index", coef_index, 0);
      rst = 1'b0;
      step();
      chk("post_rst_data", coef_data, 0);

      // First load: 0x00..0x1F.
      load_all(1'b0, 8'h00);

      // Bank 1 stream, then a request at E_(N+1) chains a bank 0 stream with
      // a stray mid-stream request that must be ignored.
      do_request(1'b1);
      check_beats(1'b1, 0, N-1, 1'b0);
      coef_select  = 1'b0;
      request_coef = 1'b1;
      step();
      request_coef = 1'b0;
      chk("chain_busy", busy, 1);
      chk("chain_valid", coef_valid, 0);
      chk("chain_hold_data", coef_data, m_mem[2*N-1]);
      check_beats(1'b0, 0, N-1, 1'b1);
      step();
      chk_idle("after_b0");
      chk("after_b0_hold", coef_data, m_mem[N-1]);
      chk("after_b0_loaded", image_weights_loaded, 1);

      // Reload at beat 5.
      do_request(1'b0);
      check_beats(1'b0, 0, 5, 1'b0);
      reload = 1'b1;
      step();
      reload = 1'b0;
      chk_idle("reload_abort");
      chk("reload_loaded", image_weights_loaded, 0);
      chk("reload_hold", coef_data, m_mem[5]);
      load_all(1'b0, 8'hA0);
      do_request(1'b0);
      check_beats(1'b0, 0, N-1, 1'b0);
      step();
      chk_idle("after_a0");

      // Reload and request on the same edge in READY; requests in LOAD ignored.
      reload       = 1'b1;
      request_coef = 1'b1;
      step();
      reload       = 1'b0;
      request_coef = 1'b0;
      chk_idle("reload_req");
      chk("reload_req_loaded", image_weights_loaded, 0);
      for (int j = 0; j < 3; j++) begin
         request_coef = 1'b1;
         step();
         request_coef = 1'b0;
         step();
         chk_idle("load_req");
      end
      load_all(1'b1, 8'h00);
      do_request(1'b1);
      check_beats(1'b1, 0, N-1, 1'b0);
      step();
      chk_idle("after_rnd");

      // Asynchronous reset between edges mid-stream.
      do_request(1'b1);
      check_beats(1'b1, 0, 3, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk_idle("async_rst");
      chk("async_rst_loaded", image_weights_loaded, 0);
      chk("async_rst_data", coef_data, 0);
      chk("async_rst_index", coef_index, 0);
      for (int i = 0; i < 2*N; i++) m_mem[i] = 8'h00;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int j = 0; j < 2; j++) begin
         request_coef = 1'b1;
         coef_select  = 1'($urandom);
         step();
         request_coef = 1'b0;
         step();
         chk_idle("post_rst_req");
      end
      load_all(1'b1, 8'h00);
      do_request(1'b0);
      check_beats(1'b0, 0, N-1, 1'b0);
      step();
      chk_idle("final");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
